// File: rtl/div_sequencer.sv
// Control sequencer for the unsigned restoring divider: LOAD, WIDTH subtract/shift
// iterations, a final shift-right, then a held rdy. Divide-by-zero skips the datapath.
module div_sequencer #(
  parameter int WIDTH = 32,
  parameter int CW    = $clog2(WIDTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          div_zero,
  output logic          w_ctrl_reg2,
  output logic          SLL_ctrl,
  output logic          SRL_ctrl,
  output logic          busy,
  output logic          rdy,
  output logic          err_dz,
  output logic [CW-1:0] iter
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_ITER = 3'd2,
    S_FIX  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  localparam logic [CW-1:0] ITER_LAST = CW'(WIDTH - 1);

  state_t          state_q, state_d;
  logic            start_q;
  logic            dz_q, dz_d;
  logic            accept;
  logic            load_q, load_d;
  logic            sll_q, sll_d;
  logic            srl_q, srl_d;
  logic            busy_q, busy_d;
  logic            rdy_q, rdy_d;
  logic            err_dz_q, err_dz_d;
  logic [CW-1:0]   iter_q, iter_d;

  // State, start-edge history and divide-by-zero marker.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      start_q <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      start_q <= start;
      dz_q    <= dz_d;
    end
  end

  // Next-state logic; only a fresh start edge in IDLE/DONE is accepted.
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    dz_d    = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        accept = start & ~start_q;
        dz_d   = start & ~start_q & div_zero;
        if (accept) begin
          state_d = div_zero ? S_DONE : S_LOAD;
        end else begin
          state_d = state_q;
        end
      end
      S_LOAD: state_d = S_ITER;
      S_ITER: begin
        if (iter_q == ITER_LAST) begin
          state_d = S_FIX;
        end else begin
          state_d = S_ITER;
        end
      end
      S_FIX:   state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode of the next state, so controls change on the same edge as the state.
  always_comb begin
    load_d = (state_d == S_LOAD);
    sll_d  = (state_d == S_ITER);
    srl_d  = (state_d == S_FIX);
    busy_d = (state_d == S_LOAD) || (state_d == S_ITER) || (state_d == S_FIX);
    // A divide-by-zero accept reports rdy/err_dz one edge later, as a fresh completion.
    rdy_d  = (state_d == S_DONE) && !dz_d;
    if (accept) begin
      err_dz_d = 1'b0;
    end else if (dz_q) begin
      err_dz_d = 1'b1;
    end else begin
      err_dz_d = err_dz_q;
    end
    if ((state_d == S_ITER) && (state_q == S_ITER)) begin
      iter_d = iter_q + CW'(1);
    end else begin
      iter_d = {CW{1'b0}};
    end
  end

  // Registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      load_q   <= 1'b0;
      sll_q    <= 1'b0;
      srl_q    <= 1'b0;
      busy_q   <= 1'b0;
      rdy_q    <= 1'b0;
      err_dz_q <= 1'b0;
      iter_q   <= {CW{1'b0}};
    end else begin
      load_q   <= load_d;
      sll_q    <= sll_d;
      srl_q    <= srl_d;
      busy_q   <= busy_d;
      rdy_q    <= rdy_d;
      err_dz_q <= err_dz_d;
      iter_q   <= iter_d;
    end
  end

  assign w_ctrl_reg2 = load_q;
  assign SLL_ctrl    = sll_q;
  assign SRL_ctrl    = srl_q;
  assign busy        = busy_q;
  assign rdy         = rdy_q;
  assign err_dz      = err_dz_q;
  assign iter        = iter_q;

endmodule

// File: tb/tb_div_sequencer.sv
// Bench for div_sequencer: drives operations against a negedge restoring-divider
// model and scoreboards quotient/remainder/err_dz at each completion.
module tb_div_sequencer;
  localparam int W  = 32;
  localparam int CW = $clog2(W + 1);

  logic          clk = 1'b0;
  logic          rst, start, div_zero;
  logic          w_ctrl_reg2, SLL_ctrl, SRL_ctrl, busy, rdy, err_dz;
  logic [CW-1:0] iter;

  always #5 clk = ~clk;

  div_sequencer #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .div_zero(div_zero),
    .w_ctrl_reg2(w_ctrl_reg2), .SLL_ctrl(SLL_ctrl), .SRL_ctrl(SRL_ctrl),
    .busy(busy), .rdy(rdy), .err_dz(err_dz), .iter(iter)
  );

  int n_vec = 0;
  int n_err = 0;
  logic mon_en = 1'b0;
  logic [31:0] opa, opb;
  logic [64:0] dp_q;

  typedef struct packed {
    logic        dz;
    logic [31:0] q;
    logic [31:0] r;
  } exp_t;
  exp_t sb[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_vec++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h at %0t", tag, obs, exp_v, $time);
    end
  endtask

  function automatic logic [64:0] dp_step(input logic [64:0] r, input logic [31:0] d);
    logic [32:0] hi;
    logic        ge;
    hi = r[64:32];
    ge = (hi >= {1'b0, d});
    if (ge) hi = hi - {1'b0, d};
    return {hi[31:0], r[31:0], ge};
  endfunction

  // Restoring-divider datapath, updated on the falling edge from the controls.
  always @(negedge clk or posedge rst) begin
    if (rst)              dp_q <= '0;
    else if (w_ctrl_reg2) dp_q <= {32'd0, opa, 1'b0};
    else if (SLL_ctrl)    dp_q <= dp_step(dp_q, opb);
    else if (SRL_ctrl)    dp_q[64:32] <= {1'b0, dp_q[64:33]};
  end

  always @(negedge clk) begin
    if (mon_en && !rst) begin
      chk("onehot", 64'($countones({w_ctrl_reg2, SLL_ctrl, SRL_ctrl}) <= 1), 64'd1);
      chk("busy_rdy", 64'(busy & rdy), 64'd0);
      chk("iter_outside", 64'(SLL_ctrl ? {CW{1'b0}} : iter), 64'd0);
    end
  end

  task automatic collect();
    exp_t e;
    chk("sb_size", 64'(sb.size()), 64'd1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk("err_dz", 64'(err_dz), 64'(e.dz));
      if (!e.dz) begin
        chk("quot", 64'(dp_q[31:0]), 64'(e.q));
        chk("rem", 64'(dp_q[63:32]), 64'(e.r));
      end
    end
  endtask

  // mode 0: single pulse, 1: start held ~50 cycles, 2: extra start edges during ITER
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input int mode);
    exp_t e;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    opa = a; opb = b; div_zero = (b == 32'd0); start = 1'b1;
    e.dz = (b == 32'd0);
    e.q  = e.dz ? 32'd0 : a / b;
    e.r  = e.dz ? 32'd0 : a % b;
    sb.push_back(e);
    @(posedge clk); #1;
    if (e.dz) begin
      chk("dz_p0", 64'({w_ctrl_reg2, SLL_ctrl, SRL_ctrl, busy, rdy}), 64'(5'b00000));
      @(negedge clk); div_zero = 1'b0;
      if (mode != 1) start = 1'b0;
      @(posedge clk); #1;
      chk("dz_p1", 64'({w_ctrl_reg2, SLL_ctrl, SRL_ctrl, busy, rdy}), 64'(5'b00001));
      collect();
    end else begin
      chk("load", 64'({w_ctrl_reg2, SLL_ctrl, SRL_ctrl, busy, rdy, err_dz}), 64'(6'b100100));
      @(negedge clk);
      if (mode != 1) start = 1'b0;
      for (int i = 0; i < W; i++) begin
        @(posedge clk); #1;
        chk("sll", 64'({w_ctrl_reg2, SLL_ctrl, SRL_ctrl, busy, rdy}), 64'(5'b01010));
        chk("iter", 64'(iter), 64'(i));
        if (mode == 2) begin
          @(negedge clk); start = i[0];
        end
      end
      if (mode == 2) start = 1'b0;
      @(posedge clk); #1;
      chk("fix", 64'({w_ctrl_reg2, SLL_ctrl, SRL_ctrl, busy, rdy}), 64'(5'b00110));
      @(posedge clk); #1;
      chk("done", 64'({w_ctrl_reg2, SLL_ctrl, SRL_ctrl, busy, rdy}), 64'(5'b00001));
      chk("iter_done", 64'(iter), 64'd0);
      collect();
    end
    if (mode == 1) begin
      for (int k = 0; k < 14; k++) begin
        @(posedge clk); #1;
        chk("held_rdy", 64'({busy, rdy}), 64'(2'b01));
      end
      @(negedge clk); start = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; start = 1'b0; div_zero = 1'b0; opa = '0; opb = '0;
    repeat (2) @(negedge clk);
    chk("reset_outs", 64'({w_ctrl_reg2, SLL_ctrl, SRL_ctrl, busy, rdy, err_dz}), 64'd0);
    chk("reset_iter", 64'(iter), 64'd0);
    rst = 1'b0;
    mon_en = 1'b1;

    run_op(32'd100, 32'd7, 0);
    run_op(32'hFFFF_FFFF, 32'd1, 0);
    run_op(32'd9, 32'd3, 0);
    run_op(32'd5, 32'd0, 0);
    run_op(32'd20, 32'd4, 0);
    run_op(32'd1000, 32'd33, 1);
    run_op(32'd12345678, 32'd1000, 2);
    run_op(32'd7, 32'd0, 1);

    // Abort an operation at iter 10 with an asynchronous reset.
    @(negedge clk); start = 1'b0;
    @(negedge clk); opa = 32'd500; opb = 32'd3; start = 1'b1;
    @(posedge clk); #1;
    @(negedge clk); start = 1'b0;
    repeat (11) @(posedge clk);
    #1;
    chk("pre_rst_iter", 64'(iter), 64'd10);
    #2 rst = 1'b1;
    #1;
    chk("rst_outs", 64'({w_ctrl_reg2, SLL_ctrl, SRL_ctrl, busy, rdy, err_dz}), 64'd0);
    chk("rst_iter", 64'(iter), 64'd0);
    @(negedge clk);
    chk("rst_hold", 64'({w_ctrl_reg2, SLL_ctrl, SRL_ctrl, busy, rdy}), 64'd0);
    rst = 1'b0;

    run_op(32'd77, 32'd5, 0);
    for (int n = 0; n < 3; n++) begin
      run_op($urandom, $urandom_range(1, 32'h0001_FFFF), 0);
    end

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
